// File: rtl/pdp_mem_arb.sv
// pdp_mem_arb: shares one single-port memory between NUM_CH PDP-8 requestors.
// Grant is combinational (fixed priority or round-robin). A lock keeps ownership
// across a read-modify-write pair. Read returns are tagged with the one-hot id
// of the requesting channel and emerge RD_LATENCY cycles after the grant.
//
//   state    | meaning
//   UNLOCKED | any requester may win arbitration
//   LOCKED   | only channel owner_q may be granted; rr_ptr frozen
module pdp_mem_arb #(
  parameter int NUM_CH     = 3,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12,
  parameter int RD_LATENCY = 1,
  parameter int PRIO_MODE  = 0
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [NUM_CH-1:0]              ch_req_i,
  input  logic [NUM_CH-1:0]              ch_we_i,
  input  logic [NUM_CH-1:0]              ch_lock_i,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]   ch_addr_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   ch_wdata_i,
  output logic [NUM_CH-1:0]              ch_gnt_o,
  output logic [NUM_CH-1:0]              ch_rvalid_o,
  output logic [DATA_WIDTH-1:0]          ch_rdata_o,
  output logic                           mem_req_o,
  output logic                           mem_we_o,
  output logic [ADDR_WIDTH-1:0]          mem_addr_o,
  output logic [DATA_WIDTH-1:0]          mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]          mem_rdata_i
);

  localparam int PTR_W = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;

  if (NUM_CH < 2 || NUM_CH > 8 || RD_LATENCY < 1 || RD_LATENCY > 4 ||
      (PRIO_MODE != 0 && PRIO_MODE != 1) || ADDR_WIDTH < 1 || DATA_WIDTH < 1) begin : g_param_check
    $error("pdp_mem_arb: parameter out of range");
  end

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_e;

  lock_state_e          state_q, state_d;
  logic [PTR_W-1:0]     owner_q, owner_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NUM_CH-1:0]    rd_pipe_q [RD_LATENCY];

  logic [NUM_CH-1:0]    eligible;
  logic [NUM_CH-1:0]    gnt;
  logic [PTR_W-1:0]     win;
  logic                 win_vld;

  // Arbitration: pick one winner among eligible requesters; reset suppresses grants.
  always_comb begin
    int idx;
    idx      = 0;
    win      = '0;
    win_vld  = 1'b0;
    eligible = reset_i ? '0 : ch_req_i;
    if (state_q == LOCKED) begin
      eligible = eligible & (NUM_CH'(1) << owner_q);
    end
    if (PRIO_MODE == 0) begin
      // Descending scan so the lowest index is the last (winning) assignment.
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (eligible[i]) begin
          win     = PTR_W'(i);
          win_vld = 1'b1;
        end
      end
    end else begin
      for (int j = 0; j < NUM_CH; j++) begin
        idx = (int'(rr_ptr_q) + j) % NUM_CH;
        if (!win_vld && eligible[idx]) begin
          win     = PTR_W'(idx);
          win_vld = 1'b1;
        end
      end
    end
    gnt = win_vld ? (NUM_CH'(1) << win) : '0;
  end

  // Memory-side mux from the granted channel; zero when idle.
  always_comb begin
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt[i]) begin
        mem_we_o    = ch_we_i[i];
        mem_addr_o  = ch_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        mem_wdata_o = ch_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Lock FSM next state and round-robin pointer update.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      UNLOCKED: begin
        if (win_vld) begin
          rr_ptr_d = (win == PTR_W'(NUM_CH - 1)) ? '0 : win + 1'b1;
          if (ch_lock_i[win]) begin
            state_d = LOCKED;
            owner_d = win;
          end
        end
      end
      LOCKED: begin
        // Owner may still be granted in the release cycle.
        if (!ch_lock_i[owner_q]) state_d = UNLOCKED;
      end
      default: state_d = UNLOCKED;
    endcase
  end

  // State registers for lock ownership and round-robin pointer.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= UNLOCKED;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Return-tag pipeline: a nonzero one-hot entry is a valid pending read.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int s = 0; s < RD_LATENCY; s++) rd_pipe_q[s] <= '0;
    end else begin
      rd_pipe_q[0] <= gnt & ~ch_we_i;
      for (int s = 1; s < RD_LATENCY; s++) rd_pipe_q[s] <= rd_pipe_q[s-1];
    end
  end

  assign ch_gnt_o    = gnt;
  assign mem_req_o   = |gnt;
  assign ch_rvalid_o = rd_pipe_q[RD_LATENCY-1];
  assign ch_rdata_o  = (|rd_pipe_q[RD_LATENCY-1]) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_pdp_mem_arb.sv
// Bench for pdp_mem_arb: three instances (fixed/lat1, round-robin/lat3,
// fixed/lat2) share stimulus; each has its own memory and reference model.
module tb_pdp_mem_arb;
  localparam int NCH = 3;
  localparam int AW  = 12;
  localparam int DW  = 12;
  localparam int NI  = 3;

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 3 : 2);
  endfunction
  function automatic int mode_of(input int g);
    return (g == 1) ? 1 : 0;
  endfunction
  function automatic logic [11:0] init_word(input int a);
    logic [11:0] w;
    if (a == 8) w = 12'o1234;
    else if (a == 9) w = 12'o4321;
    else w = 12'(a * 37 + 5);
    return w;
  endfunction

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  req   = '0;
  logic [2:0]  we    = '0;
  logic [2:0]  lock  = '0;
  logic [35:0] addr  = '0;
  logic [35:0] wdata = '0;

  logic [2:0]  gnt    [NI];
  logic [2:0]  rvalid [NI];
  logic [11:0] rdata  [NI];
  logic        mreq   [NI];
  logic        mwe    [NI];
  logic [11:0] maddr  [NI];
  logic [11:0] mwdata [NI];
  logic [11:0] mrdata [NI];

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // reference model state
  int          m_ptr    [NI];
  bit          m_locked [NI];
  int          m_owner  [NI];
  logic [2:0]  exp_rv   [NI][16];
  logic [11:0] exp_rd   [NI][16];
  logic [11:0] mdl_mem  [NI][4096];

  // values sampled in the most recent step
  logic [2:0]  s_gnt [NI];
  logic [2:0]  s_rv  [NI];
  logic [11:0] s_rd  [NI];
  logic [11:0] s_maddr [NI];
  logic [11:0] s_mwdata [NI];
  logic        s_mreq [NI];
  logic        s_mwe  [NI];

  for (genvar g = 0; g < NI; g++) begin : g_inst
    logic [11:0] mem [4096];
    logic [11:0] rp [4];
    logic        init_done = 1'b0;

    pdp_mem_arb #(
      .NUM_CH(NCH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
      .RD_LATENCY(lat_of(g)), .PRIO_MODE(mode_of(g))
    ) u_dut (
      .clk_i(clk), .reset_i(reset),
      .ch_req_i(req), .ch_we_i(we), .ch_lock_i(lock),
      .ch_addr_i(addr), .ch_wdata_i(wdata),
      .ch_gnt_o(gnt[g]), .ch_rvalid_o(rvalid[g]), .ch_rdata_o(rdata[g]),
      .mem_req_o(mreq[g]), .mem_we_o(mwe[g]), .mem_addr_o(maddr[g]),
      .mem_wdata_o(mwdata[g]), .mem_rdata_i(mrdata[g])
    );

    always @(posedge clk) begin
      if (!init_done) begin
        for (int a = 0; a < 4096; a++) mem[a] <= init_word(a);
        init_done <= 1'b1;
      end else if (mreq[g] && mwe[g]) begin
        mem[maddr[g]] <= mwdata[g];
      end
      rp[0] <= (mreq[g] && !mwe[g]) ? mem[maddr[g]] : 12'o0;
      for (int s = 1; s < 4; s++) rp[s] <= rp[s-1];
    end
    assign mrdata[g] = rp[lat_of(g)-1];
  end

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_ptr[i] = 0; m_locked[i] = 1'b0; m_owner[i] = 0;
      for (int s = 0; s < 16; s++) exp_rv[i][s] = 3'b000;
    end
  endtask

  task automatic idle();
    req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
  endtask

  task automatic drive(input int ch, input bit r, input bit w, input bit l,
                       input logic [11:0] a, input logic [11:0] d);
    req[ch] = r; we[ch] = w; lock[ch] = l;
    addr[ch*AW +: AW] = a; wdata[ch*DW +: DW] = d;
  endtask

  // One clock: sample at negedge, score against the model, advance the model.
  task automatic step();
    int eg; int slot; int due;
    logic [2:0] eg_oh; logic [11:0] ea; logic [11:0] ed; logic e_we; bit was_locked;
    @(negedge clk);
    slot = cyc % 16;
    for (int i = 0; i < NI; i++) begin
      s_gnt[i] = gnt[i]; s_rv[i] = rvalid[i]; s_rd[i] = rdata[i];
      s_mreq[i] = mreq[i]; s_mwe[i] = mwe[i]; s_maddr[i] = maddr[i]; s_mwdata[i] = mwdata[i];
      eg = -1;
      if (!reset) begin
        if (m_locked[i]) begin
          if (req[m_owner[i]]) eg = m_owner[i];
        end else begin
          for (int o = 0; o < NCH; o++) begin
            int c;
            c = (mode_of(i) == 1) ? (m_ptr[i] + o) % NCH : o;
            if (eg < 0 && req[c]) eg = c;
          end
        end
      end
      eg_oh = 3'b000; ea = 12'o0; ed = 12'o0; e_we = 1'b0;
      if (eg >= 0) begin
        eg_oh = 3'(1 << eg);
        ea = addr[eg*AW +: AW];
        ed = wdata[eg*DW +: DW];
        e_we = we[eg];
      end
      n_vec++;
      if (gnt[i] !== eg_oh) begin n_err++;
        $display("FAIL grant inst%0d cyc%0d got %b want %b", i, cyc, gnt[i], eg_oh); end
      n_vec++;
      if (mreq[i] !== (eg >= 0)) begin n_err++;
        $display("FAIL mem_req inst%0d cyc%0d got %b want %b", i, cyc, mreq[i], (eg >= 0)); end
      n_vec++;
      if (mwe[i] !== e_we) begin n_err++;
        $display("FAIL mem_we inst%0d cyc%0d got %b want %b", i, cyc, mwe[i], e_we); end
      n_vec++;
      if (maddr[i] !== ea) begin n_err++;
        $display("FAIL mem_addr inst%0d cyc%0d got %o want %o", i, cyc, maddr[i], ea); end
      n_vec++;
      if (mwdata[i] !== ed) begin n_err++;
        $display("FAIL mem_wdata inst%0d cyc%0d got %o want %o", i, cyc, mwdata[i], ed); end
      n_vec++;
      if (rvalid[i] !== exp_rv[i][slot]) begin n_err++;
        $display("FAIL rvalid inst%0d cyc%0d got %b want %b", i, cyc, rvalid[i], exp_rv[i][slot]); end
      if (exp_rv[i][slot] != 3'b000) begin
        n_vec++;
        if (rdata[i] !== exp_rd[i][slot]) begin n_err++;
          $display("FAIL rdata inst%0d cyc%0d got %o want %o", i, cyc, rdata[i], exp_rd[i][slot]); end
      end
      exp_rv[i][slot] = 3'b000;
      if (reset) begin
        m_ptr[i] = 0; m_locked[i] = 1'b0; m_owner[i] = 0;
        for (int s = 0; s < 16; s++) exp_rv[i][s] = 3'b000;
      end else begin
        was_locked = m_locked[i];
        if (eg >= 0) begin
          if (e_we) mdl_mem[i][ea] = ed;
          else begin
            due = (cyc + lat_of(i)) % 16;
            exp_rv[i][due] = eg_oh;
            exp_rd[i][due] = mdl_mem[i][ea];
          end
          if (!was_locked) m_ptr[i] = (eg + 1) % NCH;
        end
        if (was_locked) begin
          if (!lock[m_owner[i]]) m_locked[i] = 1'b0;
        end else if (eg >= 0 && lock[eg]) begin
          m_locked[i] = 1'b1; m_owner[i] = eg;
        end
      end
    end
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int c = 0; c < NCH; c++) drive(c, 1'b1, 1'b0, 1'b0, 12'($urandom), 12'($urandom));
    repeat (2) begin
      step();
      for (int i = 0; i < NI; i++) begin
        n_vec++;
        if (s_gnt[i] !== 3'b000 || s_mreq[i] !== 1'b0) begin n_err++;
          $display("FAIL reset_grant inst%0d got gnt=%b req=%b want 000/0", i, s_gnt[i], s_mreq[i]); end
      end
    end
    reset = 1'b0; idle();
    step();
    for (int i = 0; i < NI; i++) begin
      n_vec++;
      if ({s_gnt[i], s_rv[i], s_rd[i], s_mreq[i], s_mwe[i], s_maddr[i], s_mwdata[i]} !== '0) begin n_err++;
        $display("FAIL reset_outputs inst%0d got gnt=%b rv=%b rd=%o addr=%o want all 0",
                 i, s_gnt[i], s_rv[i], s_rd[i], s_maddr[i]); end
    end
  endtask

  task automatic test_fixed_prio();
    idle();
    drive(0, 1'b1, 1'b0, 1'b0, 12'o100, 12'o0);
    drive(2, 1'b1, 1'b0, 1'b0, 12'o200, 12'o0);
    for (int k = 0; k < 6; k++) begin
      step();
      for (int i = 0; i < NI; i += 2) begin
        n_vec++;
        if (s_gnt[i] !== 3'b001) begin n_err++;
          $display("FAIL fixed_grant inst%0d k%0d got %b want 001", i, k, s_gnt[i]); end
      end
      if (k > 0) begin
        n_vec++;
        if (s_rv[0] !== 3'b001) begin n_err++;
          $display("FAIL fixed_rvalid k%0d got %b want 001", k, s_rv[0]); end
      end
    end
    idle();
    step();
    n_vec++;
    if (s_rv[0] !== 3'b001) begin n_err++;
      $display("FAIL fixed_last_rvalid got %b want 001", s_rv[0]); end
    repeat (3) step();
  endtask

  task automatic test_round_robin();
    reset = 1'b1; idle(); step(); reset = 1'b0;
    for (int c = 0; c < NCH; c++) drive(c, 1'b1, 1'b1, 1'b0, 12'(12'o300 + c), 12'($urandom));
    for (int k = 0; k < 6; k++) begin
      step();
      n_vec++;
      if (s_gnt[1] !== 3'(1 << (k % 3))) begin n_err++;
        $display("FAIL rr_order k%0d got %b want %b", k, s_gnt[1], 3'(1 << (k % 3))); end
      n_vec++;
      if (s_gnt[0] !== 3'b001) begin n_err++;
        $display("FAIL rr_fixed_ref k%0d got %b want 001", k, s_gnt[0]); end
    end
    idle(); step();
  endtask

  task automatic test_read_latency();
    logic [2:0] rv_log [NI][8];
    logic [11:0] rd_log [NI][8];
    logic [2:0] want;
    reset = 1'b1; idle(); step(); reset = 1'b0;
    for (int k = 0; k < 7; k++) begin
      idle();
      if (k == 0) drive(1, 1'b1, 1'b0, 1'b0, 12'o010, 12'o0);
      if (k == 1) drive(0, 1'b1, 1'b0, 1'b0, 12'o011, 12'o0);
      step();
      for (int i = 0; i < NI; i++) begin rv_log[i][k] = s_rv[i]; rd_log[i][k] = s_rd[i]; end
    end
    for (int i = 0; i < NI; i++) begin
      for (int k = 0; k < 7; k++) begin
        want = (k == lat_of(i)) ? 3'b010 : ((k == lat_of(i) + 1) ? 3'b001 : 3'b000);
        n_vec++;
        if (rv_log[i][k] !== want) begin n_err++;
          $display("FAIL latency_rvalid inst%0d k%0d got %b want %b", i, k, rv_log[i][k], want); end
        if (want != 3'b000) begin
          n_vec++;
          if (rd_log[i][k] !== ((want == 3'b010) ? 12'o1234 : 12'o4321)) begin n_err++;
            $display("FAIL latency_rdata inst%0d k%0d got %o", i, k, rd_log[i][k]); end
        end
      end
    end
  endtask

  task automatic test_lock();
    logic [11:0] wd;
    logic [2:0] want [5];
    want[0] = 3'b010; want[1] = 3'b000; want[2] = 3'b000; want[3] = 3'b010; want[4] = 3'b001;
    wd = 12'($urandom);
    for (int k = 0; k < 5; k++) begin
      idle();
      case (k)
        0: drive(1, 1'b1, 1'b0, 1'b1, 12'o050, 12'o0);
        1, 2: begin drive(0, 1'b1, 1'b0, 1'b0, 12'o060, 12'o0); lock[1] = 1'b1; end
        3: begin drive(0, 1'b1, 1'b0, 1'b0, 12'o060, 12'o0); drive(1, 1'b1, 1'b1, 1'b0, 12'o050, wd); end
        default: drive(0, 1'b1, 1'b0, 1'b0, 12'o060, 12'o0);
      endcase
      step();
      for (int i = 0; i < NI; i++) begin
        n_vec++;
        if (s_gnt[i] !== want[k]) begin n_err++;
          $display("FAIL lock_grant inst%0d k%0d got %b want %b", i, k, s_gnt[i], want[k]); end
        if (k == 3) begin
          n_vec++;
          if (s_mwe[i] !== 1'b1 || s_maddr[i] !== 12'o050 || s_mwdata[i] !== wd) begin n_err++;
            $display("FAIL lock_write inst%0d got we=%b addr=%o data=%o want 1/50/%o",
                     i, s_mwe[i], s_maddr[i], s_mwdata[i], wd); end
        end
      end
    end
    idle();
    repeat (3) step();
  endtask

  task automatic test_write();
    idle();
    drive(2, 1'b1, 1'b1, 1'b0, 12'o7777, 12'o0001);
    step();
    for (int i = 0; i < NI; i++) begin
      n_vec++;
      if (s_gnt[i] !== 3'b100 || s_mwe[i] !== 1'b1 || s_maddr[i] !== 12'o7777 || s_mwdata[i] !== 12'o0001) begin
        n_err++;
        $display("FAIL write_issue inst%0d got gnt=%b we=%b addr=%o data=%o want 100/1/7777/0001",
                 i, s_gnt[i], s_mwe[i], s_maddr[i], s_mwdata[i]); end
    end
    idle();
    for (int k = 0; k < 4; k++) begin
      step();
      for (int i = 0; i < NI; i++) begin
        n_vec++;
        if (s_rv[i] !== 3'b000 || s_mwe[i] !== 1'b0) begin n_err++;
          $display("FAIL write_no_return inst%0d k%0d got rv=%b we=%b want 000/0", i, k, s_rv[i], s_mwe[i]); end
      end
    end
  endtask

  task automatic test_reset_midflight();
    idle();
    drive(0, 1'b1, 1'b0, 1'b1, 12'($urandom), 12'o0);
    step();
    for (int i = 0; i < NI; i++) begin
      n_vec++;
      if (s_gnt[i] !== 3'b001) begin n_err++;
        $display("FAIL midreset_grant inst%0d got %b want 001", i, s_gnt[i]); end
    end
    idle(); lock[0] = 1'b1; reset = 1'b1;
    step();
    n_vec++;
    if (s_rv[2] !== 3'b000) begin n_err++;
      $display("FAIL midreset_rv_during inst2 got %b want 000", s_rv[2]); end
    reset = 1'b0;
    step();
    for (int i = 0; i < NI; i++) begin
      n_vec++;
      if ({s_gnt[i], s_rv[i], s_rd[i], s_mreq[i], s_mwe[i], s_maddr[i], s_mwdata[i]} !== '0) begin n_err++;
        $display("FAIL midreset_zero inst%0d got gnt=%b rv=%b rd=%o want all 0", i, s_gnt[i], s_rv[i], s_rd[i]); end
    end
    drive(1, 1'b1, 1'b0, 1'b0, 12'o070, 12'o0);
    step();
    for (int i = 0; i < NI; i++) begin
      n_vec++;
      if (s_gnt[i] !== 3'b010) begin n_err++;
        $display("FAIL midreset_unlock inst%0d got %b want 010", i, s_gnt[i]); end
    end
    idle();
    for (int k = 0; k < 4; k++) begin
      step();
      for (int i = 1; i < NI; i++) begin
        n_vec++;
        if (s_rv[i][0] !== 1'b0) begin n_err++;
          $display("FAIL midreset_dropped inst%0d k%0d got rv=%b want bit0 clear", i, k, s_rv[i]); end
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      reset = ($urandom_range(0, 99) == 0);
      for (int c = 0; c < NCH; c++)
        drive(c, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0),
              12'($urandom_range(0, 15)), 12'($urandom));
      step();
    end
    reset = 1'b0; idle();
    repeat (5) step();
  endtask

  initial begin
    for (int i = 0; i < NI; i++)
      for (int a = 0; a < 4096; a++) mdl_mem[i][a] = init_word(a);
    reset = 1'b1; idle();
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    test_reset();
    test_fixed_prio();
    test_round_robin();
    test_read_latency();
    test_lock();
    test_write();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pdp_mem_arb.md
Name: pdp_mem_arb

Overview:
- Parametrised N-channel arbiter between PDP-8 memory requestors (IFU fetch, exec read, exec write, optional DMA/debug) and a single-port memory with fixed read latency.
- Successor to the per-requestor wiring at system level: one shared memory port, selectable fixed-priority or round-robin arbitration.
- Adds a lock for read-modify-write sequences (ISZ, JMS operand write).
- Tags read returns so each channel sees only its own data.

Parameters:
- NUM_CH, 3: number of requestor channels, 2..8; channel 0 is highest priority in fixed mode.
- ADDR_WIDTH, 12: memory address width.
- DATA_WIDTH, 12: memory data width.
- RD_LATENCY, 1: cycles from accepted read to mem_rdata valid, 1..4.
- PRIO_MODE, 0: 0 = fixed priority; 1 = round-robin.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- ch_req  in  NUM_CH  per-channel request, held until granted
- ch_we  in  NUM_CH  per-channel write enable (1 = write, 0 = read)
- ch_lock  in  NUM_CH  keep ownership after this grant
- ch_addr  in  NUM_CH*ADDR_WIDTH  packed addresses, channel i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- ch_wdata  in  NUM_CH*DATA_WIDTH  packed write data
- ch_gnt  out  NUM_CH  one-hot grant; request accepted this cycle
- ch_rvalid  out  NUM_CH  one-hot read-return strobe
- ch_rdata  out  DATA_WIDTH  shared read-return data, qualified by ch_rvalid
- mem_req  out  1  memory access this cycle
- mem_we  out  1  memory write
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  valid RD_LATENCY cycles after a read mem_req

Behaviour:
- Reset: ch_gnt, ch_rvalid, mem_req and mem_we = 0; ch_rdata, mem_addr and mem_wdata = 0; rr_ptr = 0; lock owner cleared; return pipeline flushed.
- Grant: combinational from ch_req, rr_ptr and lock state. At most one ch_gnt bit per cycle.
- mem_req = |ch_gnt. mem_we, mem_addr and mem_wdata are muxed from the granted channel in the same cycle.
- Fixed mode: lowest-index requester wins.
- Round-robin mode:
  - Search starts at rr_ptr and wraps modulo NUM_CH.
  - On any unlocked grant to channel k, rr_ptr <= (k+1) mod NUM_CH.
  - A channel that keeps requesting is granted within NUM_CH grants.
- Lock FSM, states UNLOCKED and LOCKED(k):
  - UNLOCKED -> LOCKED(k) on a grant to k with ch_lock[k] = 1.
  - While LOCKED(k), only ch_req[k] can be granted; other requests wait.
  - rr_ptr does not advance while locked.
  - LOCKED(k) -> UNLOCKED on the first cycle ch_lock[k] = 0. A grant to k in that same cycle is allowed and ends the lock.
  - Cycles of LOCKED(k) with ch_req[k] = 0 produce no grant.
- Read return:
  - Shift pipeline of depth RD_LATENCY carries {valid, one-hot channel id}.
  - A read grant in cycle t gives ch_rvalid = that channel's one-hot and ch_rdata = mem_rdata in cycle t+RD_LATENCY.
  - ch_rvalid is registered from the pipeline tail. ch_rdata is a pass-through of mem_rdata and is meaningful only when ch_rvalid is set.
  - Back-to-back reads, one per cycle, return in issue order with no bubbles.
- Write grant: no ch_rvalid.
- Reset mid-operation: in-flight reads are dropped with no ch_rvalid after reset; the lock is released.
- Out-of-range parameters are caught by an elaboration-time assertion.

Test Plan:
- PRIO_MODE=0, NUM_CH=3. Channels 0 and 2 request reads at 0o100 and 0o200 every cycle -> channel 0 granted every cycle, channel 2 never granted; ch_rvalid=3'b001 one cycle after each grant (RD_LATENCY=1).
- PRIO_MODE=1, all three channels hold ch_req -> grant order 0,1,2,0,1,2; rr_ptr wraps 2 -> 0.
- RD_LATENCY=3. Channel 1 reads 0o010 (memory 0o1234), then channel 0 reads 0o011 (0o4321) on the next cycle -> ch_rvalid=010 with data 0o1234 at t+3, then 001 with 0o4321 at t+4.
- Lock: channel 1 reads 0o050 with lock=1, channel 0 requests meanwhile, then channel 1 writes 0o050 with lock=0 -> channel 0 not granted until after the write; memory write seen at 0o050.
- Write from channel 2 (addr 0o7777, data 0o0001) -> mem_we=1 for one cycle, no ch_rvalid.
- RD_LATENCY=2. reset asserted one cycle after a read grant -> no ch_rvalid afterwards; all outputs 0 the cycle after reset.
